// File: rtl/write_pointer_full.sv
// write_pointer_full: async FIFO write pointer, read-pointer synchronizer, full/overflow flags.
// Optional registered almost_full when WPTR_ALMOST_FULL_EN is defined.
module write_pointer_full #(
  parameter int ADDBITS      = 2,
  parameter int WIDTH        = ADDBITS + 1,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = 2**ADDBITS - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               count,
  input  logic [WIDTH-1:0]   rpointer,
  output logic [WIDTH-1:0]   wpointer,
  output logic [ADDBITS-1:0] waddr,
  output logic               wen,
  output logic               full,
  output logic               overflow,
  output logic               almost_full
);
  // Full when the read pointer differs only in the two top Gray bits.
  localparam logic [WIDTH-1:0] FLIP = ~({WIDTH{1'b1}} >> 2);
  logic [WIDTH-1:0] wbin_q, wbin_d, wgray_q, wgray_d, rsync_last;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] rsync_q;
  logic full_q, ovf_q;
  assign wen        = count & ~full_q;
  assign wbin_d     = wbin_q + WIDTH'(wen);
  assign wgray_d    = wbin_d ^ (wbin_d >> 1);
  assign rsync_last = rsync_q[SYNC_STAGES-1];
  assign wpointer   = wgray_q;
  assign waddr      = wbin_q[ADDBITS-1:0];
  assign full       = full_q;
  assign overflow   = ovf_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rsync_q <= '0;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rsync_q <= {rsync_q[SYNC_STAGES-2:0], rpointer};
      full_q  <= wgray_d == (rsync_last ^ FLIP);
      ovf_q   <= ovf_q | (count & full_q);
    end
  end
`ifdef WPTR_ALMOST_FULL_EN
  logic [WIDTH-1:0] rbin_s, lvl;
  logic af_q;
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i < WIDTH; i++) rbin_s[i] = ^(rsync_last >> i);
  end
  assign lvl         = wbin_d - rbin_s;
  assign almost_full = af_q;
  always_ff @(posedge clk) begin
    if (!rst) af_q <= 1'b0;
    else      af_q <= lvl >= WIDTH'(AFULL_THRESH);
  end
`else
  assign almost_full = 1'b0;
`endif
endmodule

// File: tb/tb_write_pointer_full.sv
// tb_write_pointer_full: scoreboard bench for write_pointer_full (ADDBITS=2, SYNC_STAGES=2).
module tb_write_pointer_full;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       count = 1'b1;
  logic [2:0] rpointer = '0;
  logic [2:0] wpointer;
  logic [1:0] waddr;
  logic       wen, full, overflow, almost_full;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    logic [2:0] wp;
    logic       f;
    logic       o;
    logic       af;
  } exp_t;
  exp_t sb[$];
  write_pointer_full dut (
    .clk(clk), .rst(rst), .count(count), .rpointer(rpointer),
    .wpointer(wpointer), .waddr(waddr), .wen(wen), .full(full),
    .overflow(overflow), .almost_full(almost_full)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [2:0] gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction
  task automatic score(input string tag);
    exp_t e;
    logic eaf;
    e = sb.pop_front();
`ifdef WPTR_ALMOST_FULL_EN
    eaf = e.af;
`else
    eaf = 1'b0;
`endif
    check({tag, ".wpointer"}, 8'(wpointer), 8'(e.wp));
    check({tag, ".full"}, 8'(full), 8'(e.f));
    check({tag, ".overflow"}, 8'(overflow), 8'(e.o));
    check({tag, ".almost_full"}, 8'(almost_full), 8'(eaf));
  endtask
  task automatic do_reset(input string tag, input logic [1:0] ea, input logic ew, input bit pre);
    @(negedge clk);
    rst = 1'b0; count = 1'b1; rpointer = '0;
    sb.push_back('{3'b000, 1'b0, 1'b0, 1'b0});
    #1;
    if (pre) begin
      check({tag, ".pre_waddr"}, 8'(waddr), 8'(ea));
      check({tag, ".pre_wen"}, 8'(wen), 8'(ew));
    end
    @(posedge clk); #1;
    score(tag);
    check({tag, ".waddr"}, 8'(waddr), 8'd0);
    check({tag, ".wen"}, 8'(wen), 8'd1);
  endtask
  task automatic cyc(input string tag, input logic c, input logic [2:0] rp,
                     input logic [1:0] ea, input logic ew,
                     input logic [2:0] ewp, input logic ef, input logic eo, input logic eaf);
    @(negedge clk);
    rst = 1'b1; count = c; rpointer = rp;
    sb.push_back('{ewp, ef, eo, eaf});
    #1;
    check({tag, ".waddr"}, 8'(waddr), 8'(ea));
    check({tag, ".wen"}, 8'(wen), 8'(ew));
    @(posedge clk); #1;
    score(tag);
  endtask
  initial begin
    do_reset("reset", 2'd0, 1'b0, 1'b0);
    cyc("fill0", 1, 3'b000, 2'd0, 1, 3'b001, 0, 0, 0);
    cyc("fill1", 1, 3'b000, 2'd1, 1, 3'b011, 0, 0, 0);
    cyc("fill2", 1, 3'b000, 2'd2, 1, 3'b010, 0, 0, 1);
    cyc("fill3", 1, 3'b000, 2'd3, 1, 3'b110, 1, 0, 1);
    cyc("ovf0",  1, 3'b000, 2'd0, 0, 3'b110, 1, 1, 1);
    cyc("ovf1",  0, 3'b000, 2'd0, 0, 3'b110, 1, 1, 1);
    cyc("drain1", 0, 3'b001, 2'd0, 0, 3'b110, 1, 1, 1);
    cyc("drain2", 0, 3'b001, 2'd0, 0, 3'b110, 1, 1, 1);
    cyc("drain3", 0, 3'b001, 2'd0, 0, 3'b110, 0, 1, 1);
    cyc("refill", 1, 3'b001, 2'd0, 1, 3'b111, 1, 1, 1);
    do_reset("midrst", 2'd1, 1'b0, 1'b1);
    // Read side keeps pace; the two-stage lag holds occupancy at 3 at most.
    for (int c = 0; c < 16; c++) begin
      logic [2:0] b;
      b = 3'(c);
      cyc($sformatf("wrap%0d", c), 1, gray(b), b[1:0], 1, gray(b + 3'd1), 0, 0, c >= 2);
    end
    check("sb_empty", 8'(sb.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/write_pointer_full.md
# write_pointer_full

Write-side pointer controller for the asynchronous FIFO; the write-domain counterpart of the read-pointer/empty logic. Keeps a binary and a Gray-coded write pointer, produces the memory write address and write enable, and synchronizes the read-domain Gray pointer into the write clock. It also generates a registered `full` flag and a sticky `overflow` flag. It sits between the write-side client, the dual-port memory write port, and the read-pointer block.

## Interface
- `ADDBITS`, 2, memory address width; FIFO depth = 2^ADDBITS; legal values ≥ 1.
- `WIDTH`, ADDBITS+1, pointer width including the wrap bit.
- `SYNC_STAGES`, 2, flop stages in the `rpointer` synchronizer; legal values ≥ 2.
- `AFULL_THRESH`, 2^ADDBITS-1, occupancy at or above which `almost_full` asserts; used only with the macro.
- `clk`  in  1  write-domain clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `count`  in  1  write request from the client.
- `rpointer`  in  WIDTH  Gray read pointer, asynchronous to `clk`.
- `wpointer`  out  WIDTH  registered Gray write pointer, sent to the read domain.
- `waddr`  out  ADDBITS  memory write address, equal to `wbin[ADDBITS-1:0]`.
- `wen`  out  1  memory write enable, equal to `count & ~full` (combinational).
- `full`  out  1  registered full flag.
- `overflow`  out  1  sticky flag: a write was attempted while `full` was high.
- `almost_full`  out  1  registered almost-full flag; tied to 0 without the macro.

## Operation
- Internal state:
  - `wbin`: WIDTH-bit binary write pointer.
  - `wpointer`: registered Gray code of `wbin`, computed as `bin ^ (bin>>1)`.
  - `rsync`: a chain of SYNC_STAGES × WIDTH flops; the last stage is the synchronized read pointer.
- Increment: when `wen`=1, `wbin` is incremented by 1 modulo 2^WIDTH.
  - `wpointer` is updated on the same edge to gray(`wbin`+1).
  - Otherwise both `wbin` and `wpointer` hold.
- Next Gray value: `wgray_next` = gray(`wbin` + `wen`).
- Full flag: `full` <= (`wgray_next` == {~rsync[WIDTH-1], ~rsync[WIDTH-2], rsync[WIDTH-3:0]}).
  - For ADDBITS=1 the comparison uses only the two inverted MSBs.
- Overflow: `overflow` <= `overflow` | (`count` & `full`). It clears only on reset.
- A write with `full`=1 is dropped: the pointer does not move and `wen`=0.
- Reset (`rst`=0 at a rising edge) takes priority over every other input. It sets:
  - `wbin`, `wpointer`, every synchronizer stage, `full`, `overflow` and `almost_full` to 0.
  - As a result `waddr`=0 and `wen`=`count`.
- Wrap-around: `wbin` rolls over from 2^WIDTH-1 to 0 and `wpointer` follows the Gray sequence. No special case is needed.
- Simultaneous write and read-pointer advance: `full` is evaluated against the stale `rsync`. It may stay high for up to SYNC_STAGES+1 cycles after the read side frees space. This is conservative and required; `full` must never assert late.

## Timing
- Write latency: `waddr` and `wen` are valid in the cycle `count` is presented. The memory captures data on that edge, and `wpointer` advances on the same edge.
- `full` asserts on the same edge as the write that fills the FIFO. This is zero-cycle lookahead via `wgray_next`.
- Read-pointer propagation: a change on `rpointer` reaches `rsync` after SYNC_STAGES edges. It affects `full` on the next edge, i.e. SYNC_STAGES+1 edges total (3 by default).
- `overflow` sets one edge after a cycle with `count`=1 and `full`=1.
- `wpointer` changes exactly one bit per increment, which makes it safe for the read-side synchronizer.

## Configuration
- Macro: `WPTR_ALMOST_FULL_EN`.
- Defined:
  - `rsync` is converted Gray→binary to give `rbin_s`.
  - Occupancy is computed as `lvl` = (`wbin` + `wen` − `rbin_s`) mod 2^WIDTH.
  - `almost_full` <= (`lvl` ≥ AFULL_THRESH). It resets to 0 and has the same synchronizer latency as `full`.
- Not defined:
  - No converter or subtractor is built.
  - `almost_full` is a constant 0.
  - All other behaviour is identical.

## Test plan
All scenarios use ADDBITS=2 and SYNC_STAGES=2.
- **Reset:** drive `rst`=0 for one edge with `count`=1 → `wpointer`=000, `waddr`=0, `full`=0, `overflow`=0, `almost_full`=0.
- **Fill:** hold `rpointer`=000 and `count`=1 for 4 edges → `waddr` reads 0,1,2,3 in those cycles. `wpointer` steps 001, 011, 010, 110, and `full`=1 after the 4th edge.
- **Overflow:** with `full`=1, hold `count`=1 → `wen`=0, `wpointer` stays 110, and `overflow`=1 after one edge. `overflow` stays 1 after `count` drops.
- **Drain visibility:** from full, set `rpointer`=001 → `full` is still 1 after edges 1 and 2 and drops to 0 after edge 3. The next write then goes to `waddr`=0.
- **Wrap:** stream 16 writes with `rpointer` tracking gray(`wbin`−1) → `full` never asserts, and `wpointer` returns to 000 after the 8th and 16th writes.
- **Mid-operation reset and almost-full:**
  - With `full`=1 and `count`=1, drive `rst`=0 → all outputs return to reset values on that edge.
  - With `WPTR_ALMOST_FULL_EN` defined and `AFULL_THRESH`=3, three writes against `rpointer`=000 → `almost_full`=1 after the 3rd edge and `full`=0.
